// File: rtl/conv_encoder_param.sv
// Framed rate-1/N_OUT feed-forward convolutional encoder: encodes L information
// bits, then appends K-1 zero tail bits, behind a backpressured output register.
module conv_encoder_param #(
  parameter int                 K           = 3,
  parameter int                 N_OUT       = 2,
  parameter logic [N_OUT*K-1:0] G_POLY      = 6'b101_111,
  parameter int                 FRAME_LEN_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [FRAME_LEN_W-1:0] i_frame_len,
  input  logic                   i_valid,
  input  logic                   i_data,
  output logic                   o_ready,
  output logic [N_OUT-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam logic [FRAME_LEN_W-1:0] CNT_ZERO = '0;
  localparam logic [FRAME_LEN_W-1:0] CNT_ONE  = FRAME_LEN_W'(1);
  localparam logic [FRAME_LEN_W-1:0] TAIL_LEN = FRAME_LEN_W'(K - 1);

  // Tap vector is {din, sr[0], ..., sr[K-2]}; generator j occupies G_POLY[j*K +: K].
  function automatic logic [N_OUT-1:0] encode_symbol(input logic din, input logic [K-2:0] sr);
    logic [K-1:0]     taps;
    logic [N_OUT-1:0] sym;
    taps[K-1] = din;
    for (int i = 0; i < K - 1; i++) begin
      taps[K-2-i] = sr[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      sym[j] = ^(taps & G_POLY[j*K +: K]);
    end
    return sym;
  endfunction

  function automatic logic [K-2:0] shift_in(input logic din, input logic [K-2:0] sr);
    return {sr[K-3:0], din};
  endfunction

  state_e                 state_q, state_d;
  logic [K-2:0]           sr_q, sr_d;
  logic [FRAME_LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN_W-1:0] tail_cnt_q, tail_cnt_d;
  logic [FRAME_LEN_W-1:0] len_q, len_d;
  logic [N_OUT-1:0]       o_data_q, o_data_d;
  logic                   o_valid_q, o_valid_d;
  logic                   o_last_q, o_last_d;
  logic                   out_free_s;
  logic                   ready_s;

  assign out_free_s = !o_valid_q || i_ready;
  assign ready_s    = (state_q == ST_ENCODE) && out_free_s;

  // Next-state, shift register, counters and output-register load
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    len_d      = len_q;
    o_data_d   = o_data_q;
    o_valid_d  = o_valid_q & ~i_ready;
    o_last_d   = o_last_q & ~i_ready;
    case (state_q)
      ST_IDLE: begin
        if (i_start && (i_frame_len != CNT_ZERO)) begin
          len_d      = i_frame_len;
          sr_d       = '0;
          bit_cnt_d  = CNT_ZERO;
          tail_cnt_d = CNT_ZERO;
          state_d    = ST_ENCODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENCODE: begin
        if (i_valid && ready_s) begin
          o_data_d  = encode_symbol(i_data, sr_q);
          o_valid_d = 1'b1;
          sr_d      = shift_in(i_data, sr_q);
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          if ((bit_cnt_q + CNT_ONE) == len_q) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_ENCODE;
          end
        end else begin
          state_d = ST_ENCODE;
        end
      end
      ST_FLUSH: begin
        // Tail bits are zeros pushed through the same symbol path.
        if ((tail_cnt_q != TAIL_LEN) && out_free_s) begin
          o_data_d   = encode_symbol(1'b0, sr_q);
          o_valid_d  = 1'b1;
          sr_d       = shift_in(1'b0, sr_q);
          tail_cnt_d = tail_cnt_q + CNT_ONE;
          o_last_d   = ((tail_cnt_q + CNT_ONE) == TAIL_LEN);
        end else if (o_valid_q && o_last_q && i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= CNT_ZERO;
      tail_cnt_q <= CNT_ZERO;
      len_q      <= CNT_ZERO;
      o_data_q   <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      len_q      <= len_d;
      o_data_q   <= o_data_d;
      o_valid_q  <= o_valid_d;
      o_last_q   <= o_last_d;
    end
  end

  assign o_ready = ready_s;
  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed bench for conv_encoder_param: table-driven frames on the default
// K=3 encoder plus hand sequences for reset, zero length and a K=7 impulse.
module tb_conv_encoder_param;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] frame_len;
  logic        valid;
  logic        data;
  logic        ready;
  logic        o_ready;
  logic [1:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_busy;

  logic        k_start;
  logic [15:0] k_len;
  logic        k_valid;
  logic        k_data;
  logic        k_ready;
  logic        k_oready;
  logic [1:0]  k_odata;
  logic        k_ovalid;
  logic        k_olast;
  logic        k_obusy;

  int checks;
  int errors;

  conv_encoder_param u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_len(frame_len),
    .i_valid(valid), .i_data(data), .o_ready(o_ready), .o_data(o_data),
    .o_valid(o_valid), .i_ready(ready), .o_last(o_last), .o_busy(o_busy)
  );

  conv_encoder_param #(
    .K(7), .N_OUT(2), .G_POLY({7'b1011011, 7'b1111001}), .FRAME_LEN_W(16)
  ) u_k7 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(k_start), .i_frame_len(k_len),
    .i_valid(k_valid), .i_data(k_data), .o_ready(k_oready), .o_data(k_odata),
    .o_valid(k_ovalid), .i_ready(k_ready), .o_last(k_olast), .o_busy(k_obusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      len;
    logic [0:15]      bits;
    int               n_sym;
    logic [0:7][1:0]  exp;
    bit               stall;
    bit               mid_start;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic run_frame(input logic [15:0] len, input logic [0:15] bits, input int n_sym,
                           input logic [0:17][1:0] exp, input bit stall, input bit mid_start,
                           input bit rnd_valid, input string tag);
    logic [1:0] got_sym [$];
    logic       got_last [$];
    logic [1:0] held;
    int         idx;
    int         stall_left;
    int         stall_done;
    int         cyc;
    int         n;
    bit         stalled;
    bit         done;
    @(posedge clk); #1;
    start = 1'b1; frame_len = len; valid = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; stall_left = 0; stall_done = 0; cyc = 0; done = 1'b0; held = 2'b00;
    while (!done && cyc < 200) begin
      stalled = 1'b0;
      if (stall && stall_left == 0 && stall_done < 2 && o_valid &&
          got_sym.size() == ((stall_done == 0) ? 1 : 4)) begin
        stall_left = 3;
        stall_done++;
      end
      if (stall_left > 0) begin
        ready = 1'b0; stall_left--; stalled = 1'b1; held = o_data;
      end else begin
        ready = 1'b1;
      end
      valid = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
      data  = (idx < 16) ? bits[idx] : 1'b1;
      start = mid_start && (idx == 2);
      frame_len = (mid_start && idx == 2) ? 16'd7 : len;
      @(negedge clk);
      if (stalled) begin
        chk({tag, "_stall_ordy"}, 32'(o_ready), 32'd0);
      end
      if (o_valid && ready) begin
        got_sym.push_back(o_data);
        got_last.push_back(o_last);
        done = o_last;
      end
      if (valid && o_ready) idx++;
      @(posedge clk); #1;
      cyc++;
      if (stalled) begin
        chk({tag, "_hold_data"}, 32'(o_data), 32'(held));
        chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
      end
    end
    start = 1'b0; valid = 1'b0; ready = 1'b1;
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    chk({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    chk({tag, "_valid_after"}, 32'(o_valid), 32'd0);
    chk({tag, "_bits_used"}, 32'(idx), 32'(len));
    chk({tag, "_count"}, 32'(got_sym.size()), 32'(n_sym));
    n = (got_sym.size() < n_sym) ? got_sym.size() : n_sym;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), 32'(got_sym[i]), 32'(exp[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == n_sym - 1));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"},  32'(o_data),  32'd0);
    chk({tag, "_last"},  32'(o_last),  32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
  endtask

  initial begin
    logic [0:15]      rb;
    logic [0:17][1:0] exp_r;
    logic [0:6][1:0]  k_exp;
    logic             b, p1, p2;
    int               acc;
    int               cyc;
    int               n;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; frame_len = 16'd0; valid = 1'b0; data = 1'b0; ready = 1'b1;
    k_start = 1'b0; k_len = 16'd0; k_valid = 1'b0; k_data = 1'b0; k_ready = 1'b1;

    //            len    bits                    n  symbols {o1,o0}                  stall mid
    tbl[0] = '{16'd4, 16'b1011_0000_0000_0000, 6, 16'b11_01_00_10_10_11_00_00, 1'b0, 1'b0};
    tbl[1] = '{16'd1, 16'b1000_0000_0000_0000, 3, 16'b11_01_11_00_00_00_00_00, 1'b0, 1'b0};
    tbl[2] = '{16'd3, 16'b0110_0000_0000_0000, 5, 16'b00_11_10_10_11_00_00_00, 1'b0, 1'b0};
    tbl[3] = '{16'd2, 16'b1100_0000_0000_0000, 4, 16'b11_10_10_11_00_00_00_00, 1'b0, 1'b0};
    tbl[4] = '{16'd4, 16'b1011_0000_0000_0000, 6, 16'b11_01_00_10_10_11_00_00, 1'b1, 1'b0};
    tbl[5] = '{16'd4, 16'b1011_0000_0000_0000, 6, 16'b11_01_00_10_10_11_00_00, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_frame(tbl[v].len, tbl[v].bits, tbl[v].n_sym, {tbl[v].exp, 20'b0},
                tbl[v].stall, tbl[v].mid_start, 1'b0, $sformatf("vec%0d", v));
    end

    // Zero-length start must be ignored.
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'd0; valid = 1'b1; data = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("zlen_busy%0d", i), 32'(o_busy), 32'd0);
      chk($sformatf("zlen_valid%0d", i), 32'(o_valid), 32'd0);
    end
    valid = 1'b0;

    // Asynchronous reset after two accepted bits of an L=8 frame.
    @(posedge clk); #1;
    start = 1'b1; frame_len = 16'd8; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b1; data = 1'b1; acc = 0; cyc = 0;
    while (acc < 2 && cyc < 20) begin
      @(negedge clk);
      if (valid && o_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    valid = 1'b0;
    chk("rst_accepts", 32'(acc), 32'd2);
    chk("rst_busy_before", 32'(o_busy), 32'd1);
    chk("rst_valid_before", 32'(o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(tbl[0].len, tbl[0].bits, tbl[0].n_sym, {tbl[0].exp, 20'b0},
              1'b0, 1'b0, 1'b0, "post_rst");

    // Random i_valid at L=16 against an independent G=111/101 model.
    rb = 16'($urandom());
    p1 = 1'b0; p2 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      b = (i < 16) ? rb[i] : 1'b0;
      exp_r[i] = {b ^ p2, b ^ p1 ^ p2};
      p2 = p1;
      p1 = b;
    end
    run_frame(16'd16, rb, 18, exp_r, 1'b0, 1'b0, 1'b1, "rnd");

    // K=7 impulse response on the second instance.
    k_exp = 14'b11_01_11_11_00_10_11;
    @(posedge clk); #1;
    k_start = 1'b1; k_len = 16'd1;
    @(posedge clk); #1;
    k_start = 1'b0; k_valid = 1'b1; k_data = 1'b1;
    n = 0; cyc = 0;
    while (n < 7 && cyc < 50) begin
      @(negedge clk);
      if (k_ovalid && k_ready) begin
        chk($sformatf("k7_sym%0d", n), 32'(k_odata), 32'(k_exp[n]));
        chk($sformatf("k7_last%0d", n), 32'(k_olast), 32'(n == 6));
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    k_valid = 1'b0;
    chk("k7_count", 32'(n), 32'd7);
    chk("k7_busy_after", 32'(k_obusy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised rate-1/N_OUT, constraint-length-K feed-forward convolutional encoder. It is the framed successor to the fixed K=3, G=[111][101] encoder.
- Accepts a frame of information bits over a valid/ready handshake.
- Emits one N_OUT-bit symbol per input bit, then automatically appends K-1 zero tail bits to terminate the trellis.
- Sits between the bit source and the channel/Viterbi decoder test path.
- Output is registered and honours downstream backpressure.

Parameters:
K, 3, constraint length (register depth K-1), legal 3..9
N_OUT, 2, number of generator polynomials / output bits per symbol, legal 2..4
G_POLY, 6'b101_111, packed generators; G_j = G_POLY[j*K +: K] drives o_data[j]; bit K-1 of G_j taps the current input
FRAME_LEN_W, 16, width of frame-length field

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse: latch i_frame_len and begin a frame
i_frame_len  input  FRAME_LEN_W  number of information bits L in the frame
i_valid  input  1  i_data valid
i_data  input  1  information bit
o_ready  output  1  encoder accepts i_data this cycle
o_data  output  N_OUT  encoded symbol, bit j from G_j
o_valid  output  1  o_data valid
i_ready  input  1  downstream accepts o_data
o_last  output  1  marks final tail symbol of frame
o_busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset is asynchronous, active-low; clock is i_clk. On reset:
  - state=IDLE, shift register sr[K-2:0]=0, bit and tail counters=0.
  - o_valid=0, o_data=0, o_last=0, o_ready=0, o_busy=0.
- FSM states: IDLE, ENCODE, FLUSH.
  - IDLE: i_start with i_frame_len!=0 latches L, clears sr, and goes to ENCODE. i_start with L=0 is ignored and the FSM stays in IDLE.
  - ENCODE: o_ready = !o_valid || i_ready. On an accept (i_valid && o_ready):
    - compute the symbol from tap vector t = {i_data, sr[0], ..., sr[K-2]}, with t[K-1]=i_data and sr[0] = most recent bit;
    - o_data[j] = XOR of (t & G_j);
    - register the symbol into o_data, set o_valid=1;
    - shift sr (sr[0]<=i_data);
    - increment the bit counter.
    After the L-th accept, go to FLUSH.
  - FLUSH: o_ready=0. Inject K-1 zero bits, one per cycle in which (!o_valid || i_ready), using the same symbol math with i_data forced to 0. The (K-1)-th tail symbol sets o_last=1. On its hand-off, go to IDLE.
- Latency: accepted bit to o_valid is 1 cycle. A frame of L bits produces exactly L+K-1 symbols.
- Output register:
  - o_data, o_valid and o_last hold stable while o_valid && !i_ready.
  - o_valid clears on i_ready when no new symbol is loaded in the same cycle.
  - Full throughput is 1 symbol per cycle with i_ready tied high.
- o_last is asserted only together with o_valid on the final tail symbol, and clears on its hand-off.
- i_start while o_busy=1 is ignored. The latched L is unaffected.
- i_valid in IDLE or FLUSH is ignored and no bit is consumed.
- o_busy remains 1 until the last symbol is handed off, i.e. o_valid && i_ready with o_last=1.
- Reset mid-frame immediately clears all state. No tail is emitted and the partial frame is discarded.
- Counters are FRAME_LEN_W wide and do not wrap, because the bound is L.

Test Plan:
1. Defaults, i_frame_len=4, bits 1,0,1,1 back-to-back, i_ready=1 -> o_data sequence (as {o1,o0}) 11,01,00,10,10,11; 6 symbols; o_last only on the 6th; o_busy drops the cycle after.
2. K=7, N_OUT=2, G_POLY={7'b1011011,7'b1111001}, L=1, bit 1 -> impulse response 11,01,11,11,00,10,11 with o_last on the 7th.
3. Test 1 with i_ready low for 3 cycles at symbol 2 and symbol 5 -> o_data/o_valid held stable; o_ready=0 while stalled in ENCODE; identical final sequence.
4. i_start with i_frame_len=0 -> stays IDLE, o_busy=0, no o_valid. i_start pulsed mid-frame -> ignored, symbol count still L+K-1.
5. i_rst_n asserted after 2 accepted bits of an L=8 frame -> all outputs 0 asynchronously. A new L=4 frame then reproduces test 1 exactly, showing sr is cleared.
6. i_valid toggling randomly at L=16 with i_ready=1 -> output matches a reference model, with 18 symbols and a single o_last.
